// File: rtl/uno_turn_scheduler.sv
// uno_turn_scheduler
// ------------------
// Sequences UNO turns among the human seat (seat 0) and the computer seats.
// One seat is granted at a time. The block applies the effects of action cards
// (skip, reverse, draw-two, wild draw-four) and requests penalty or pass cards
// from the shared deck with a request/ack handshake. It also detects the end
// of the game.
//
// Parameters
//   NUM_SEATS       number of seats (2..4)
//   FIRST_SEAT      seat granted the first turn after a start
//   TIMEOUT_CYCLES  turn timeout in i_clk cycles (used only when the
//                   TURN_TIMEOUT_EN macro is defined)
//
// Optional feature macro: TURN_TIMEOUT_EN
//   When defined, a seat that takes no action within TIMEOUT_CYCLES cycles of
//   WAIT is forced to draw one card, exactly as if it had passed.
//   When undefined, WAIT holds indefinitely and no counter is built.
//
// Ports
//   i_clk          system clock (1 MHz domain)
//   i_rst          asynchronous active-high reset
//   i_start        level; a rising edge starts a game from IDLE or DONE
//   i_play_valid   pulse: the granted seat plays i_play_card
//   i_play_card    [5:4] colour, [3:0] value (10 skip, 11 reverse,
//                  12 draw-two, 13 wild, 14 wild draw-four)
//   i_pass         pulse: the granted seat draws one card and ends its turn
//   i_hand_nums    7-bit hand count per seat, seat s at [7s+6:7s]
//   i_draw_ack     deck delivered one card to o_draw_seat
//   o_seat         granted seat
//   o_turn_start   one-cycle pulse when a seat is granted
//   o_draw_req     level; one card is wanted for o_draw_seat
//   o_draw_seat    seat receiving the drawn card
//   o_prev_card    top of the discard pile
//   o_dir          0 = clockwise (+1), 1 = counter-clockwise (-1)
//   o_finished     game over
//   o_winner       winning seat, valid while o_finished = 1
//   o_state        FSM state encoding for the debug display
module uno_turn_scheduler #(
    parameter int          NUM_SEATS      = 4,
    parameter int          FIRST_SEAT     = 0,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_play_valid,
    input  logic [5:0]  i_play_card,
    input  logic        i_pass,
    input  logic [27:0] i_hand_nums,
    input  logic        i_draw_ack,
    output logic [1:0]  o_seat,
    output logic        o_turn_start,
    output logic        o_draw_req,
    output logic [1:0]  o_draw_seat,
    output logic [5:0]  o_prev_card,
    output logic        o_dir,
    output logic        o_finished,
    output logic [1:0]  o_winner,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_PENALTY = 3'd4,
        ST_ADVANCE = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [2:0] NSEATS_C     = 3'(NUM_SEATS);
    localparam logic [1:0] FIRST_SEAT_C = 2'(FIRST_SEAT);
    localparam logic [5:0] NO_CARD_C    = 6'b111111;

    localparam logic [3:0] VAL_SKIP_C    = 4'd10;
    localparam logic [3:0] VAL_REVERSE_C = 4'd11;
    localparam logic [3:0] VAL_DRAW2_C   = 4'd12;
    localparam logic [3:0] VAL_DRAW4_C   = 4'd14;

    // Seat reached by moving 'step' seats in direction 'dir', wrapping
    // modulo NUM_SEATS both ways (step is at most 2, so one correction suffices).
    function automatic logic [1:0] next_seat_f(input logic [1:0] seat,
                                               input logic [1:0] step,
                                               input logic       dir);
        logic [2:0] sum_v;
        if (!dir) begin
            sum_v = {1'b0, seat} + {1'b0, step};
            if (sum_v >= NSEATS_C) begin
                sum_v = sum_v - NSEATS_C;
            end else begin
                sum_v = sum_v;
            end
        end else begin
            if (seat >= step) begin
                sum_v = {1'b0, seat} - {1'b0, step};
            end else begin
                sum_v = {1'b0, seat} + NSEATS_C - {1'b0, step};
            end
        end
        return sum_v[1:0];
    endfunction

    state_t      state_r, state_nx_s;
    logic        start_d_r;
    logic [1:0]  seat_r, seat_nx_s;
    logic        dir_r, dir_nx_s;
    logic [2:0]  pend_r, pend_nx_s;
    logic [1:0]  step_r, step_nx_s;
    logic [1:0]  draw_seat_r, draw_seat_nx_s;
    logic [5:0]  prev_card_r, prev_card_nx_s;
    logic        finished_r, finished_nx_s;
    logic [1:0]  winner_r, winner_nx_s;
    logic        turn_start_r;
    logic        draw_req_r;

    logic        start_rise_s;
    logic        timeout_hit_s;
    logic        pass_s;
    logic [6:0]  hand_cur_s;

    assign start_rise_s = i_start & ~start_d_r;
    // A timeout is handled exactly like a pass from the granted seat.
    assign pass_s       = i_pass | timeout_hit_s;

`ifdef TURN_TIMEOUT_EN
    logic [19:0] to_cnt_r;

    // Turn timeout counter: cleared on grant, counts in WAIT, frozen elsewhere.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_cnt_r <= 20'd0;
        end else if (state_r == ST_GRANT) begin
            to_cnt_r <= 20'd0;
        end else if (state_r == ST_WAIT) begin
            to_cnt_r <= to_cnt_r + 20'd1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    assign timeout_hit_s = (state_r == ST_WAIT) && (to_cnt_r == (TIMEOUT_CYCLES - 20'd1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Hand count of the granted seat.
    always_comb begin
        hand_cur_s = 7'd0;
        case (seat_r)
            2'd0:    hand_cur_s = i_hand_nums[6:0];
            2'd1:    hand_cur_s = i_hand_nums[13:7];
            2'd2:    hand_cur_s = i_hand_nums[20:14];
            2'd3:    hand_cur_s = i_hand_nums[27:21];
            default: hand_cur_s = 7'd0;
        endcase
    end

    // Next-state and next-register values for the turn sequencer.
    always_comb begin
        state_nx_s     = state_r;
        seat_nx_s      = seat_r;
        dir_nx_s       = dir_r;
        pend_nx_s      = pend_r;
        step_nx_s      = step_r;
        draw_seat_nx_s = draw_seat_r;
        prev_card_nx_s = prev_card_r;
        finished_nx_s  = finished_r;
        winner_nx_s    = winner_r;

        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    seat_nx_s  = FIRST_SEAT_C;
                    dir_nx_s   = 1'b0;
                    state_nx_s = ST_GRANT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end

            ST_GRANT: begin
                state_nx_s = ST_WAIT;
            end

            ST_WAIT: begin
                // A play takes priority over a simultaneous pass.
                if (i_play_valid) begin
                    prev_card_nx_s = i_play_card;
                    state_nx_s     = ST_CHECK;
                end else if (pass_s) begin
                    pend_nx_s      = 3'd1;
                    step_nx_s      = 2'd1;
                    draw_seat_nx_s = seat_r;
                    state_nx_s     = ST_PENALTY;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end

            ST_CHECK: begin
                // The hand datapath has already removed the played card here.
                if (hand_cur_s == 7'd0) begin
                    finished_nx_s = 1'b1;
                    winner_nx_s   = seat_r;
                    state_nx_s    = ST_DONE;
                end else begin
                    pend_nx_s = 3'd0;
                    step_nx_s = 2'd1;
                    case (prev_card_r[3:0])
                        VAL_SKIP_C: begin
                            step_nx_s = 2'd2;
                        end
                        VAL_REVERSE_C: begin
                            // With two players a reverse hands the turn back, i.e. a skip.
                            if (NUM_SEATS == 2) begin
                                step_nx_s = 2'd2;
                            end else begin
                                dir_nx_s  = ~dir_r;
                                step_nx_s = 2'd1;
                            end
                        end
                        VAL_DRAW2_C: begin
                            pend_nx_s      = 3'd2;
                            draw_seat_nx_s = next_seat_f(seat_r, 2'd1, dir_r);
                            step_nx_s      = 2'd2;
                        end
                        VAL_DRAW4_C: begin
                            pend_nx_s      = 3'd4;
                            draw_seat_nx_s = next_seat_f(seat_r, 2'd1, dir_r);
                            step_nx_s      = 2'd2;
                        end
                        default: begin
                            step_nx_s = 2'd1;
                        end
                    endcase
                    if (pend_nx_s != 3'd0) begin
                        state_nx_s = ST_PENALTY;
                    end else begin
                        state_nx_s = ST_ADVANCE;
                    end
                end
            end

            ST_PENALTY: begin
                // One card per ack; the request drops once the last card is in.
                if (i_draw_ack) begin
                    pend_nx_s = pend_r - 3'd1;
                    if (pend_r == 3'd1) begin
                        state_nx_s = ST_ADVANCE;
                    end else begin
                        state_nx_s = ST_PENALTY;
                    end
                end else begin
                    state_nx_s = ST_PENALTY;
                end
            end

            ST_ADVANCE: begin
                seat_nx_s  = next_seat_f(seat_r, step_r, dir_r);
                state_nx_s = ST_GRANT;
            end

            ST_DONE: begin
                if (start_rise_s) begin
                    finished_nx_s  = 1'b0;
                    prev_card_nx_s = NO_CARD_C;
                    seat_nx_s      = FIRST_SEAT_C;
                    dir_nx_s       = 1'b0;
                    state_nx_s     = ST_GRANT;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end

            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; the pulse/level outputs are registered
    // from the next state so they line up with the state they belong to.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            start_d_r    <= 1'b0;
            seat_r       <= FIRST_SEAT_C;
            dir_r        <= 1'b0;
            pend_r       <= 3'd0;
            step_r       <= 2'd1;
            draw_seat_r  <= 2'd0;
            prev_card_r  <= NO_CARD_C;
            finished_r   <= 1'b0;
            winner_r     <= 2'd0;
            turn_start_r <= 1'b0;
            draw_req_r   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            start_d_r    <= i_start;
            seat_r       <= seat_nx_s;
            dir_r        <= dir_nx_s;
            pend_r       <= pend_nx_s;
            step_r       <= step_nx_s;
            draw_seat_r  <= draw_seat_nx_s;
            prev_card_r  <= prev_card_nx_s;
            finished_r   <= finished_nx_s;
            winner_r     <= winner_nx_s;
            turn_start_r <= (state_nx_s == ST_GRANT);
            draw_req_r   <= (state_nx_s == ST_PENALTY);
        end
    end

    assign o_seat       = seat_r;
    assign o_turn_start = turn_start_r;
    assign o_draw_req   = draw_req_r;
    assign o_draw_seat  = draw_seat_r;
    assign o_prev_card  = prev_card_r;
    assign o_dir        = dir_r;
    assign o_finished   = finished_r;
    assign o_winner     = winner_r;
    assign o_state      = state_r;

endmodule
